// File: rtl/ram_arbiter_if.sv
// One requester's req/ack port toward ram_arbiter.
// The requester drives the request side; the arbiter drives grant, ack, err and read data.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, ack, err, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a single-port RAM.
// Each transaction takes IDLE -> ACCESS -> DONE; out-of-range addresses never enable the RAM.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_arbiter_if.slave          rq0,
    ram_arbiter_if.slave          rq1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_read_en,
    output logic                  ram_write_en,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  ptr;
    logic                  win;
    logic                  win_nxt;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_capture;

    assign in_range   = lat_addr < ADDR_WIDTH'(DEPTH);
    assign rd_capture = in_range ? ram_rdata : '0;
    assign ram_addr   = lat_addr;
    assign ram_wdata  = lat_wdata;

    // Contention goes to the pointer; a lone request wins outright.
    assign win_nxt = (rq0.req && rq1.req) ? ptr : rq1.req;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rq0.req || rq1.req) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        rq0.gnt      = 1'b0;
        rq1.gnt      = 1'b0;
        rq0.ack      = 1'b0;
        rq1.ack      = 1'b0;
        rq0.err      = 1'b0;
        rq1.err      = 1'b0;
        ram_read_en  = 1'b0;
        ram_write_en = 1'b0;
        case (state)
            ACCESS: begin
                rq0.gnt      = !win;
                rq1.gnt      = win;
                ram_write_en = in_range && lat_we;
                ram_read_en  = in_range && !lat_we;
            end
            DONE: begin
                rq0.gnt = !win;
                rq1.gnt = win;
                rq0.ack = !win;
                rq1.ack = win;
                rq0.err = !win && !in_range;
                rq1.err = win && !in_range;
            end
            default: ;
        endcase
    end

    // Request latch, read-data capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rq0.rdata <= '0;
            rq1.rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rq0.req || rq1.req) begin
                        win       <= win_nxt;
                        lat_we    <= win_nxt ? rq1.we    : rq0.we;
                        lat_addr  <= win_nxt ? rq1.addr  : rq0.addr;
                        lat_wdata <= win_nxt ? rq1.wdata : rq0.wdata;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (win) rq1.rdata <= rd_capture;
                        else     rq0.rdata <= rd_capture;
                    end
                end
                DONE:    ptr <= ~win;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 32x32 RAM (combinational read).
// Stimulus pushes expected acks; a negedge monitor pops and compares them.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_read_en;
    logic        ram_write_en;
    logic [31:0] ram_rdata;

    ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) rq0 ();
    ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) rq1 ();

    ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rq0          (rq0),
        .rq1          (rq1),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_read_en  (ram_read_en),
        .ram_write_en (ram_write_en),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM; the preload port lets the bench seed contents while the arbiter is idle.
    logic [31:0] ram [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          en_count = 0;
    int          cyc = 0;

    assign ram_rdata = ram[ram_addr[4:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_read_en || ram_write_en) en_count <= en_count + 1;
        if (ram_write_en)  ram[ram_addr[4:0]] <= ram_wdata;
        else if (pre_en)   ram[pre_addr] <= pre_data;
    end

    typedef struct {
        bit          id;
        bit          err;
        bit          chk;
        logic [31:0] rdata;
        int          cycle;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: structural invariants every cycle, scoreboard pop on every ack.
    always @(negedge clk) begin
        logic [5:0] bad;
        exp_t       e;
        bit         id;
        bad = {rq0.gnt & rq1.gnt,
               ram_read_en & ram_write_en,
               (ram_read_en | ram_write_en) & ~(rq0.gnt | rq1.gnt),
               rq0.err & ~rq0.ack,
               rq1.err & ~rq1.ack,
               rq0.ack & rq1.ack};
        check("invariants", 32'(bad), 32'd0);
        if (rst_n && (rq0.ack || rq1.ack)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: ack0=%b ack1=%b with no transaction pending (cycle %0d)",
                         rq0.ack, rq1.ack, cyc);
            end else begin
                e  = sb.pop_front();
                id = rq1.ack;
                check("ack_id", 32'(id), 32'(e.id));
                check("ack_cycle", cyc, e.cycle);
                check("ack_err", 32'(id ? rq1.err : rq0.err), 32'(e.err));
                check("gnt_at_ack", 32'(id ? rq1.gnt : rq0.gnt), 32'd1);
                if (e.chk) check("ack_rdata", id ? rq1.rdata : rq0.rdata, e.rdata);
            end
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic issue(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit push, input bit err, input bit chk, input logic [31:0] rd);
        @(negedge clk);
        if (id) begin
            rq1.req = 1'b1; rq1.we = we; rq1.addr = addr; rq1.wdata = wdata;
        end else begin
            rq0.req = 1'b1; rq0.we = we; rq0.addr = addr; rq0.wdata = wdata;
        end
        // Request sampled at the next edge, ACCESS one cycle, ack visible in the cycle after.
        if (push) sb.push_back('{id: id, err: err, chk: chk, rdata: rd, cycle: cyc + 2});
    endtask

    task automatic wait_ack(input bit id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = id ? rq1.ack : rq0.ack;
        end
        check("ack_seen", 32'(seen), 32'd1);
        if (id) rq1.req = 1'b0;
        else    rq0.req = 1'b0;
    endtask

    task automatic txn(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit err, input bit chk, input logic [31:0] rd);
        issue(id, we, addr, wdata, 1'b1, err, chk, rd);
        wait_ack(id);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'({rq0.gnt, rq1.gnt}), 32'd0);
        check({tag, "_ack"},   32'({rq0.ack, rq1.ack, rq0.err, rq1.err}), 32'd0);
        check({tag, "_en"},    32'({ram_read_en, ram_write_en}), 32'd0);
        check({tag, "_rdata0"}, rq0.rdata, 32'd0);
        check({tag, "_rdata1"}, rq1.rdata, 32'd0);
        check({tag, "_addr"},  ram_addr, 32'd0);
        check({tag, "_wdata"}, ram_wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int snap;
        rq0.req = 1'b0; rq0.we = 1'b0; rq0.addr = '0; rq0.wdata = '0;
        rq1.req = 1'b0; rq1.we = 1'b0; rq1.addr = '0; rq1.wdata = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Write then read back on requester 0.
        txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        txn(1'b0, 1'b0, 32'd5, 32'd0,        1'b0, 1'b1, 32'hDEADBEEF);

        // Inputs changed during ACCESS must not reach the RAM.
        issue(1'b0, 1'b1, 32'd3, 32'h11, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("access_wdata", ram_wdata, 32'h11);
        check("access_addr", ram_addr, 32'd3);
        rq0.wdata = 32'h22;
        rq0.addr  = 32'd4;
        wait_ack(1'b0);
        txn(1'b0, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1, 32'h11);

        // Read isolation between requesters.
        preload(5'd2, 32'h2222_2222);
        preload(5'd4, 32'h4444_4444);
        txn(1'b0, 1'b0, 32'd2, 32'd0, 1'b0, 1'b1, 32'h2222_2222);
        txn(1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b1, 32'h4444_4444);
        check("isolation_rdata0", rq0.rdata, 32'h2222_2222);

        // Out-of-range accesses: err pulse, zero read data, RAM untouched.
        preload(5'd0,  32'hA0A0_A0A0);
        preload(5'd31, 32'h3131_3131);
        snap = en_count;
        txn(1'b1, 1'b0, 32'd32,        32'd0,        1'b1, 1'b1, 32'd0);
        txn(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1, 1'b1, 32'd0);
        check("oor_enables", en_count, snap);
        check("oor_ram0", ram[0], 32'hA0A0_A0A0);
        check("oor_ram31", ram[31], 32'h3131_3131);

        // Reset during the ACCESS cycle of a write.
        preload(5'd7, 32'h5);
        issue(1'b1, 1'b1, 32'd7, 32'hAA, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("midrst_write_en", 32'(ram_write_en), 32'd1);
        rst_n   = 1'b0;
        rq1.req = 1'b0;
        #1;
        check("midrst_en_drop", 32'({ram_read_en, ram_write_en}), 32'd0);
        @(negedge clk);
        check("midrst_ram7", ram[7], 32'h5);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        txn(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 1'b1, 32'h5);

        // Continuous contention from reset: grants 0,1,0,1 with acks 3 cycles apart.
        @(negedge clk);
        rst_n = 1'b0;
        rq0.req = 1'b1; rq0.we = 1'b0; rq0.addr = 32'd5; rq0.wdata = '0;
        rq1.req = 1'b1; rq1.we = 1'b1; rq1.addr = 32'd9; rq1.wdata = 32'h99;
        @(negedge clk);
        rst_n = 1'b1;
        k = cyc;
        sb.push_back('{id: 1'b0, err: 1'b0, chk: 1'b1, rdata: 32'hDEADBEEF, cycle: k + 2});
        sb.push_back('{id: 1'b1, err: 1'b0, chk: 1'b0, rdata: 32'd0,        cycle: k + 5});
        sb.push_back('{id: 1'b0, err: 1'b0, chk: 1'b1, rdata: 32'hDEADBEEF, cycle: k + 8});
        sb.push_back('{id: 1'b1, err: 1'b0, chk: 1'b0, rdata: 32'd0,        cycle: k + 11});
        for (int i = 0; i < 30 && cyc < k + 11; i++) @(negedge clk);
        rq0.req = 1'b0;
        rq1.req = 1'b0;
        repeat (4) @(negedge clk);
        check("contention_ram9", ram[9], 32'h99);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
